image_loader: RTL and testbench
===============================

Name: image_loader

Overview:
- Writer-side source for the background and spritesheet image-write port of the video pipeline.
- Accepts 32-bit words from the bridge / data-slot path over a valid/ready stream.
- Splits each word into 16-bit RGB565 background writes or 8-bit alpha spritesheet writes.
- Drives background_write_en / spritesheet_write_en / image_write_addr / image_write_data with sequential addresses, one write per clock, then reports completion.

Parameters:
- BACKGROUND_LEN, 17'd129600, number of 16-bit background writes per load (360x360).
- SPRITESHEET_LEN, 17'd32768, number of 8-bit spritesheet writes per load (15-bit address space).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- load_start  input  1  one-cycle pulse; begins a load when idle
- load_target  input  1  0 = background, 1 = spritesheet; sampled with load_start
- in_valid  input  1  input word valid
- in_data  input  32  input word
- in_ready  output  1  loader accepts in_data this cycle when in_valid && in_ready
- background_write_en  output  1  background write strobe
- spritesheet_write_en  output  1  spritesheet write strobe
- image_write_addr  output  17  write address (spritesheet uses [14:0]; [16:15] = 0)
- image_write_data  output  16  write data (spritesheet uses [7:0]; [15:8] = 0)
- busy  output  1  high from accepted load_start until done
- done  output  1  one-cycle pulse when the final write issues
- overflow  output  1  sticky; a word arrived after the length limit; cleared by next load_start
- checksum  output  16  see Optional Feature

Behaviour:
- Reset (async): state IDLE; all outputs 0; hold register empty; address and slice counters 0.
- States:
  - IDLE: in_ready=0. load_start latches target, clears address, slice, overflow and checksum, goes to LOAD, busy=1.
  - LOAD: accepts and splits words.
  - DONE: one cycle; done=1, busy=0, then IDLE.
- Hold register: one 32-bit word plus a slice index.
  - Background: 2 slices, in order [31:16] then [15:0].
  - Spritesheet: 4 slices, in order [31:24], [23:16], [15:8], [7:0].
- in_ready = LOAD && (hold empty || last slice being emitted this cycle) && remaining writes > 0.
  - Gives sustained 1 write/clock with no bubbles.
- Latency: word accepted at edge N → first write strobe registered and visible in cycle N+1.
  - Strobe, address and data are all registered and change together.
- Address: starts at 0; increments by 1 after each write. Exactly one strobe per write, selected by the latched target.
- Completion: when the write with address LEN-1 issues, the next cycle enters DONE.
  - Any remaining slices of that word are discarded, with no strobe.
  - in_ready is 0 from the cycle that write issues.
- Overflow: in LOAD with remaining writes = 0, or in DONE/IDLE after a load, in_valid held high sets overflow. The word is not accepted.
- Stall: no in_valid and hold empty → no strobe; address holds.
- load_start while busy: ignored; the latched target does not change.
- load_start in the DONE cycle: ignored.
- Reset mid-load: returns immediately to IDLE; partial image is left in memory; no done pulse.

Optional Feature:
- Macro: IMAGE_LOADER_CHECKSUM_EN.
- Defined:
  - checksum = 16-bit wrapping sum of image_write_data over every issued write of the current load.
  - Cleared by accepted load_start.
  - Updated in the same cycle the write is visible, so it is final when done pulses.
- Undefined: checksum tied to 16'h0000; no adder logic.

Test Plan:
- Background, BACKGROUND_LEN=4: load_start target 0, words 32'hAAAA_BBBB and 32'h1234_5678 back-to-back.
  - Expect background_write_en on 4 consecutive cycles: addr 0..3, data AAAA, BBBB, 1234, 5678.
  - done pulses the cycle after addr 3; spritesheet_write_en stays 0.
- Spritesheet, SPRITESHEET_LEN=8: target 1, words 32'h0102_0304 and 32'hF0E0_D0C0.
  - Expect 8 strobes: addr 0..7, data 0001, 0002, 0003, 0004, 00F0, 00E0, 00D0, 00C0.
  - in_ready high only on the cycles the hold register is empty or on its 4th slice.
- Stall: in_valid gap of 5 cycles between words.
  - Expect no strobes during the gap, address held, then resume at the next address.
- Overflow, BACKGROUND_LEN=3: send 2 words.
  - Expect 3 writes (third = high half of word 2) and done; low half dropped.
  - Extra in_valid after done → overflow=1, in_ready=0; next load_start clears overflow.
- Async reset asserted mid-load after 2 writes.
  - Expect all outputs 0 immediately, state IDLE, no done.
  - A fresh load restarts at addr 0.
- With IMAGE_LOADER_CHECKSUM_EN: background load of 16'hFFFF, 16'h0002 → checksum 16'h0001 at done.
  - Without the macro, checksum stays 16'h0000.

Source files
------------

// File: rtl/image_loader.sv
// image_loader: writer-side source for the background / spritesheet image
// write port. Takes 32-bit words over valid/ready, holds one word, and emits
// its slices as sequential 16-bit (background, RGB565) or 8-bit (spritesheet,
// alpha) writes at one write per clock, then pulses done.
//
// Optional build macro: IMAGE_LOADER_CHECKSUM_EN
//   defined   -> checksum is a 16-bit wrapping sum of every issued write's data
//   undefined -> checksum is tied to zero
module image_loader #(
    parameter logic [16:0] BACKGROUND_LEN  = 17'd129600,
    parameter logic [16:0] SPRITESHEET_LEN = 17'd32768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic        load_target,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        background_write_en,
    output logic        spritesheet_write_en,
    output logic [16:0] image_write_addr,
    output logic [15:0] image_write_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic        target_q,   target_d;    // 0 = background, 1 = spritesheet
    logic [31:0] hold_q,     hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [1:0]  slice_q,    slice_d;
    logic [16:0] cnt_q,      cnt_d;       // writes issued in this load
    logic        loaded_q,   loaded_d;    // a load has happened since reset
    logic        ovf_q,      ovf_d;
    logic        bg_we_q,    bg_we_d;
    logic        ss_we_q,    ss_we_d;
    logic [16:0] waddr_q,    waddr_d;
    logic [15:0] wdata_q,    wdata_d;

    logic [16:0] len;
    logic        rem_nz;
    logic        is_final;
    logic        last_slice;
    logic        issue;
    logic        ready;
    logic        accept;
    logic [15:0] slice_data;

    assign len        = target_q ? SPRITESHEET_LEN : BACKGROUND_LEN;
    assign rem_nz     = (cnt_q != len);
    assign is_final   = (cnt_q == len - 17'd1);
    assign last_slice = (slice_q == (target_q ? 2'd3 : 2'd1));
    assign issue      = (state_q == S_LOAD) && hold_vld_q;
    // A new word may enter while the last slice of the held one drains, but
    // never alongside the final write: its slices would be thrown away.
    assign ready      = (state_q == S_LOAD) && rem_nz &&
                        (!hold_vld_q || (last_slice && !is_final));
    assign accept     = ready && in_valid;

    // Select the current slice of the held word, most significant first.
    always_comb begin
        slice_data = 16'h0000;
        if (target_q) begin
            case (slice_q)
                2'd0:    slice_data = {8'h00, hold_q[31:24]};
                2'd1:    slice_data = {8'h00, hold_q[23:16]};
                2'd2:    slice_data = {8'h00, hold_q[15:8]};
                default: slice_data = {8'h00, hold_q[7:0]};
            endcase
        end else begin
            slice_data = slice_q[0] ? hold_q[15:0] : hold_q[31:16];
        end
    end

    // Next-state logic: FSM, hold register, write port and overflow flag.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        slice_d    = slice_q;
        cnt_d      = cnt_q;
        loaded_d   = loaded_q;
        ovf_d      = ovf_q;
        bg_we_d    = 1'b0;
        ss_we_d    = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d    = S_LOAD;
                    target_d   = load_target;
                    cnt_d      = 17'd0;
                    slice_d    = 2'd0;
                    hold_vld_d = 1'b0;
                    ovf_d      = 1'b0;
                    loaded_d   = 1'b1;
                end else if (in_valid && loaded_q) begin
                    ovf_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (issue) begin
                    bg_we_d = ~target_q;
                    ss_we_d = target_q;
                    waddr_d = cnt_q;
                    wdata_d = slice_data;
                    cnt_d   = cnt_q + 17'd1;
                    // The final write discards whatever slices remain.
                    if (last_slice || is_final) begin
                        hold_vld_d = 1'b0;
                        slice_d    = 2'd0;
                    end else begin
                        slice_d = slice_q + 2'd1;
                    end
                end
                if (accept) begin
                    hold_d     = in_data;
                    hold_vld_d = 1'b1;
                    slice_d    = 2'd0;
                end
                if (!rem_nz) begin
                    state_d = S_DONE;
                    if (in_valid) ovf_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (in_valid) ovf_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            target_q   <= 1'b0;
            hold_q     <= 32'h0;
            hold_vld_q <= 1'b0;
            slice_q    <= 2'd0;
            cnt_q      <= 17'd0;
            loaded_q   <= 1'b0;
            ovf_q      <= 1'b0;
            bg_we_q    <= 1'b0;
            ss_we_q    <= 1'b0;
            waddr_q    <= 17'd0;
            wdata_q    <= 16'h0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            slice_q    <= slice_d;
            cnt_q      <= cnt_d;
            loaded_q   <= loaded_d;
            ovf_q      <= ovf_d;
            bg_we_q    <= bg_we_d;
            ss_we_q    <= ss_we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic [15:0] cks_q, cks_d;

    // Running sum tracks the write register so it is final when done pulses.
    always_comb begin
        cks_d = cks_q;
        if (state_q == S_IDLE && load_start) cks_d = 16'h0000;
        else if (issue)                      cks_d = cks_q + slice_data;
    end

    // Checksum register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cks_q <= 16'h0000;
        else       cks_q <= cks_d;
    end

    assign checksum = cks_q;
`else
    assign checksum = 16'h0000;
`endif

    assign in_ready             = ready;
    assign background_write_en  = bg_we_q;
    assign spritesheet_write_en = ss_we_q;
    assign image_write_addr     = waddr_q;
    assign image_write_data     = wdata_q;
    assign busy                 = (state_q == S_LOAD);
    assign done                 = (state_q == S_DONE);
    assign overflow             = ovf_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader. u0 runs with BACKGROUND_LEN=4 /
// SPRITESHEET_LEN=8, u1 with BACKGROUND_LEN=3 for the truncation/overflow case.
// Both share the input stimulus; a selector picks whose outputs are checked.
module tb_image_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic        load_target = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;

    logic        u0_rdy, u0_bg, u0_ss, u0_busy, u0_done, u0_ovf;
    logic [16:0] u0_addr;
    logic [15:0] u0_data, u0_cks;
    logic        u1_rdy, u1_bg, u1_ss, u1_busy, u1_done, u1_ovf;
    logic [16:0] u1_addr;
    logic [15:0] u1_data, u1_cks;

    bit          sel = 1'b0;
    logic        m_rdy, m_bg, m_ss, m_busy, m_done, m_ovf;
    logic [16:0] m_addr;
    logic [15:0] m_data, m_cks;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    image_loader #(.BACKGROUND_LEN(17'd4), .SPRITESHEET_LEN(17'd8)) u0 (
        .clk(clk), .reset(reset), .load_start(load_start), .load_target(load_target),
        .in_valid(in_valid), .in_data(in_data), .in_ready(u0_rdy),
        .background_write_en(u0_bg), .spritesheet_write_en(u0_ss),
        .image_write_addr(u0_addr), .image_write_data(u0_data),
        .busy(u0_busy), .done(u0_done), .overflow(u0_ovf), .checksum(u0_cks));

    image_loader #(.BACKGROUND_LEN(17'd3), .SPRITESHEET_LEN(17'd8)) u1 (
        .clk(clk), .reset(reset), .load_start(load_start), .load_target(load_target),
        .in_valid(in_valid), .in_data(in_data), .in_ready(u1_rdy),
        .background_write_en(u1_bg), .spritesheet_write_en(u1_ss),
        .image_write_addr(u1_addr), .image_write_data(u1_data),
        .busy(u1_busy), .done(u1_done), .overflow(u1_ovf), .checksum(u1_cks));

    assign m_rdy  = sel ? u1_rdy  : u0_rdy;
    assign m_bg   = sel ? u1_bg   : u0_bg;
    assign m_ss   = sel ? u1_ss   : u0_ss;
    assign m_busy = sel ? u1_busy : u0_busy;
    assign m_done = sel ? u1_done : u0_done;
    assign m_ovf  = sel ? u1_ovf  : u0_ovf;
    assign m_addr = sel ? u1_addr : u0_addr;
    assign m_data = sel ? u1_data : u0_data;
    assign m_cks  = sel ? u1_cks  : u0_cks;

    typedef struct packed {
        logic            tgt;
        logic [31:0]     w0;
        logic [31:0]     w1;
        int              gap;        // in_valid low cycles after word 0
        int              poke;       // cycle of a stray load_start, -1 = none
        int              len;
        logic [15:0]     rdy_mask;   // expected in_ready per cycle after start
        logic [7:0][15:0] exp;
    } vec_t;

    vec_t tbl [4];
    vec_t ovf_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Start a load, stream two words, and check every write and the done pulse.
    task automatic run_load(input bit s, input vec_t v);
        int n, last_c, widx, gapc;
        bit acc, fin;
        logic [15:0] sum;
        sel = s; n = 0; last_c = -10; widx = 0; gapc = 0; fin = 1'b0; sum = 16'h0;
        load_target = v.tgt; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("busy_start", m_busy, 1);
        in_data = v.w0; in_valid = 1'b1;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (c < 16) check($sformatf("in_ready_c%0d", c), m_rdy, v.rdy_mask[c]);
            if (m_bg || m_ss) begin
                check("strobe_sel", {m_bg, m_ss}, v.tgt ? 2'b01 : 2'b10);
                check("extra_write", n < v.len, 1);
                check($sformatf("addr_w%0d", n), m_addr, n);
                check($sformatf("data_w%0d", n), m_data, v.exp[n[2:0]]);
                if (v.gap == 0 && n > 0) check("back2back", c - last_c, 1);
                if (v.gap > 0 && n == 2) check("stall_resume", c - last_c, v.gap);
                sum = sum + v.exp[n[2:0]];
                last_c = c;
                n++;
            end else if (n > 0 && !m_done) begin
                check("addr_hold", m_addr, n - 1);
            end
            if (m_done) begin
                check("write_count", n, v.len);
                check("done_time", c - last_c, 1);
                check("busy_at_done", m_busy, 0);
                check("ready_at_done", m_rdy, 0);
`ifdef IMAGE_LOADER_CHECKSUM_EN
                check("checksum", m_cks, sum);
`else
                check("checksum_off", m_cks, 16'h0000);
`endif
                fin = 1'b1;
            end
            if (!fin) begin
                acc = in_valid && m_rdy;
                load_start = (c == v.poke);
                if (c == v.poke) load_target = ~v.tgt;
                tick();
                load_start = 1'b0;
                if (acc) begin
                    widx++;
                    if (widx < 2) begin
                        in_data = v.w1;
                        if (v.gap > 0) begin
                            in_valid = 1'b0;
                            gapc = v.gap;
                        end
                    end else begin
                        in_valid = 1'b0;
                    end
                end else if (gapc > 0) begin
                    gapc--;
                    if (gapc == 0) in_valid = 1'b1;
                end
            end
        end
        check("done_seen", fin, 1);
    endtask

    initial begin
        int n;
        bit acc;

        tbl[0] = '{tgt: 1'b0, w0: 32'hAAAA_BBBB, w1: 32'h1234_5678, gap: 0, poke: -1,
                   len: 4, rdy_mask: 16'h0005,
                   exp: {64'h0, 16'h5678, 16'h1234, 16'hBBBB, 16'hAAAA}};
        tbl[1] = '{tgt: 1'b1, w0: 32'h0102_0304, w1: 32'hF0E0_D0C0, gap: 0, poke: 3,
                   len: 8, rdy_mask: 16'h0011,
                   exp: {16'h00C0, 16'h00D0, 16'h00E0, 16'h00F0,
                         16'h0004, 16'h0003, 16'h0002, 16'h0001}};
        tbl[2] = '{tgt: 1'b0, w0: 32'h0000_FFFF, w1: 32'h8001_7FFE, gap: 5, poke: -1,
                   len: 4, rdy_mask: 16'h007D,
                   exp: {64'h0, 16'h7FFE, 16'h8001, 16'hFFFF, 16'h0000}};
        tbl[3] = '{tgt: 1'b0, w0: 32'hFFFF_0002, w1: 32'h0000_0000, gap: 0, poke: -1,
                   len: 4, rdy_mask: 16'h0005,
                   exp: {64'h0, 16'h0000, 16'h0000, 16'h0002, 16'hFFFF}};
        ovf_v  = '{tgt: 1'b0, w0: 32'h1111_2222, w1: 32'h3333_4444, gap: 0, poke: -1,
                   len: 3, rdy_mask: 16'h0005,
                   exp: {80'h0, 16'h3333, 16'h2222, 16'h1111}};

        // Reset state of both instances.
        #2 reset = 1'b1;
        #1;
        check("reset_u0", {u0_rdy, u0_bg, u0_ss, u0_addr, u0_data, u0_busy, u0_done, u0_ovf, u0_cks}, 0);
        check("reset_u1", {u1_rdy, u1_bg, u1_ss, u1_addr, u1_data, u1_busy, u1_done, u1_ovf, u1_cks}, 0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_load(1'b0, tbl[i]);
        end

        // Asynchronous reset after two writes, then a fresh load.
        do_reset();
        sel = 1'b0;
        load_target = 1'b0; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        in_valid = 1'b1; in_data = 32'hAAAA_BBBB;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            if (u0_bg) n++;
            if (n < 2) begin
                acc = in_valid && u0_rdy;
                tick();
                if (acc) in_data = 32'h1234_5678;
            end
        end
        check("two_writes_before_reset", n, 2);
        reset = 1'b1;
        #1;
        check("reset_mid_load", {u0_rdy, u0_bg, u0_ss, u0_addr, u0_data, u0_busy, u0_done, u0_ovf, u0_cks}, 0);
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("no_done_after_reset", {u0_done, u0_bg, u0_busy}, 0);
        end
        run_load(1'b0, tbl[0]);

        // Length-3 background: low half of word 2 dropped, then overflow.
        do_reset();
        run_load(1'b1, ovf_v);
        check("ovf_clear_at_done", u1_ovf, 0);
        load_target = 1'b1; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("ls_in_done_ignored", u1_busy, 0);
        in_valid = 1'b1; in_data = 32'h5555_6666;
        check("ready_idle", u1_rdy, 0);
        tick();
        check("ovf_set", u1_ovf, 1);
        check("ovf_ready", u1_rdy, 0);
        check("ovf_no_write", {u1_bg, u1_ss}, 0);
        check("ovf_addr_hold", u1_addr, 2);
        in_valid = 1'b0;
        tick();
        check("ovf_sticky", u1_ovf, 1);
        load_target = 1'b0; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("ovf_cleared", u1_ovf, 0);
        check("busy_reload", u1_busy, 1);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
